// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 chain controller: FSM states and
// counter-width helpers.
package hc595_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } hc595_state_t;

    // Bit counter width: large enough to hold DATA_W itself.
    function automatic int bit_cnt_w(input int data_w);
        return (data_w < 1) ? 1 : $clog2(data_w + 1);
    endfunction

    // Phase counter width; a one-bit counter is the floor for CLK_DIV=2.
    function automatic int phase_cnt_w(input int clk_div);
        return (clk_div <= 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/hc595_bit_timer.sv
// CLK_DIV phase counter. Produces strobes that mark positions inside one
// bit (or latch) window so the parent can place shcp/stcp edges and step
// its bit counter.
module hc595_bit_timer
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_phase_first,
    output logic o_phase_half,
    output logic o_phase_penult,
    output logic o_phase_last
);

    localparam int PW = phase_cnt_w(CLK_DIV);
    localparam logic [PW-1:0] PH_HALF   = PW'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0] PH_PENULT = PW'(CLK_DIV - 2);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_phase;

    // Phase counter: cleared while idle, wraps at the end of each window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (i_clear) begin
            r_phase <= '0;
        end else if (i_run) begin
            if (r_phase == PH_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    // phase_half marks the last cycle of the first half of a window.
    assign o_phase_first  = (r_phase == '0);
    assign o_phase_half   = (r_phase == PH_HALF);
    assign o_phase_penult = (r_phase == PH_PENULT);
    assign o_phase_last   = (r_phase == PH_LAST);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a daisy chain of 74HC595 shift registers: shifts a
// held word out on ds/shcp, latches it with stcp, and blanks the outputs
// via oe until the first complete word has been latched.
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int DATA_W       = 14,
    parameter int CLK_DIV      = 4,
    parameter int MSB_FIRST    = 0,
    parameter int AUTO_REFRESH = 1
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_din_valid,
    output logic              o_din_ready,
    input  logic              i_out_en,
    output logic              o_ds,
    output logic              o_shcp,
    output logic              o_stcp,
    output logic              o_oe,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BW    = bit_cnt_w(DATA_W);
    localparam int EXT_W = 1 << BW;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    hc595_state_t      r_state;
    hc595_state_t      w_state_next;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] w_shadow_next;
    logic [BW-1:0]     r_bit;
    logic [BW-1:0]     w_bit_next;
    logic [BW-1:0]     w_bit_inc;
    logic              r_ds;
    logic              w_ds_next;
    logic              r_shcp;
    logic              r_stcp;
    logic              r_oe;
    logic              r_busy;
    logic              r_done;
    logic              r_first_latch;
    logic              w_timer_run;
    logic              w_timer_clear;
    logic              w_phase_first;
    logic              w_phase_half;
    logic              w_phase_penult;
    logic              w_phase_last;
    logic              w_last_bit;
    logic              w_enter_latch;
    logic              w_latch_penult;
    // Words reordered into transmit order and zero-padded so the bit
    // counter can index them directly at its full width.
    logic [EXT_W-1:0]  w_shadow_ord;
    logic [EXT_W-1:0]  w_din_ord;

    genvar gi;
    generate
        for (gi = 0; gi < EXT_W; gi++) begin : g_order
            if (gi < DATA_W) begin : g_bit
                if (MSB_FIRST != 0) begin : g_msb
                    assign w_shadow_ord[gi] = r_shadow[DATA_W-1-gi];
                    assign w_din_ord[gi]    = i_din[DATA_W-1-gi];
                end else begin : g_lsb
                    assign w_shadow_ord[gi] = r_shadow[gi];
                    assign w_din_ord[gi]    = i_din[gi];
                end
            end else begin : g_pad
                assign w_shadow_ord[gi] = 1'b0;
                assign w_din_ord[gi]    = 1'b0;
            end
        end
    endgenerate

    hc595_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .i_clk          (i_sys_clk),
        .i_rst_n        (i_sys_rst_n),
        .i_run          (w_timer_run),
        .i_clear        (w_timer_clear),
        .o_phase_first  (w_phase_first),
        .o_phase_half   (w_phase_half),
        .o_phase_penult (w_phase_penult),
        .o_phase_last   (w_phase_last)
    );

    assign w_bit_inc      = r_bit + BW'(1);
    assign w_last_bit     = (r_bit == LAST_BIT);
    assign w_enter_latch  = (r_state == ST_SHIFT) && w_phase_last && w_last_bit;
    assign w_latch_penult = (r_state == ST_LATCH) && w_phase_penult;
    assign o_din_ready    = (r_state == ST_IDLE) && i_sys_rst_n;

    // Next-state, bit select and shadow capture; new input wins over refresh.
    always_comb begin
        w_state_next  = r_state;
        w_shadow_next = r_shadow;
        w_bit_next    = r_bit;
        w_ds_next     = r_ds;
        w_timer_run   = 1'b0;
        w_timer_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_clear = 1'b1;
                w_bit_next    = '0;
                if (i_din_valid) begin
                    w_shadow_next = i_din;
                    w_ds_next     = w_din_ord[0];
                    w_state_next  = ST_SHIFT;
                end else if ((AUTO_REFRESH != 0) && r_first_latch) begin
                    w_ds_next    = w_shadow_ord[0];
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_timer_run = 1'b1;
                if (w_phase_last) begin
                    if (w_last_bit) begin
                        w_state_next = ST_LATCH;
                    end else begin
                        w_bit_next = w_bit_inc;
                        w_ds_next  = w_shadow_ord[w_bit_inc];
                    end
                end
            end
            ST_LATCH: begin
                w_timer_run = 1'b1;
                if (w_phase_last) begin
                    w_state_next = ST_IDLE;
                    w_bit_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shadow word, bit counter and first-latch flag.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_shadow      <= '0;
            r_bit         <= '0;
            r_first_latch <= 1'b0;
        end else begin
            r_shadow      <= w_shadow_next;
            r_bit         <= w_bit_next;
            r_first_latch <= r_first_latch || w_latch_penult;
        end
    end

    // Registered pin drivers, loaded with the value for the coming cycle.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_ds   <= 1'b0;
            r_shcp <= 1'b0;
            r_stcp <= 1'b0;
            r_oe   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ds   <= w_ds_next;
            // shcp rises mid-window and falls as the window closes.
            r_shcp <= (r_state == ST_SHIFT) && !w_phase_last && (w_phase_half || r_shcp);
            // stcp covers the first half of the latch window.
            r_stcp <= w_enter_latch ||
                      ((r_state == ST_LATCH) && (w_phase_first || r_stcp) && !w_phase_half);
            r_oe   <= r_first_latch ? ~i_out_en : 1'b1;
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= w_latch_penult;
        end
    end

    assign o_ds   = r_ds;
    assign o_shcp = r_shcp;
    assign o_stcp = r_stcp;
    assign o_oe   = r_oe;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: doc/hc595_chain_ctrl.md
Name: hc595_chain_ctrl

Overview:
Parametrised serial driver for a daisy-chain of 74HC595 shift registers, e.g. segment and digit-select drivers for multi-digit 7-seg boards.
- Accepts a parallel word over a valid/ready handshake and shifts it out on ds/shcp.
- Latches the word with stcp.
- Drives output-enable with glitch-free power-up blanking.
- Optional auto-refresh mode re-transmits the held word continuously.

Parameters:
DATA_W, 14, total bits in the chain (8 per 595 in a full chain); legal range 1..64.
CLK_DIV, 4, sys_clk cycles per shifted bit and per latch phase; even, >=2.
MSB_FIRST, 0, 1: din[DATA_W-1] shifted first; 0: din[0] shifted first.
AUTO_REFRESH, 1, 1: re-send the held word whenever idle with no new input; 0: one-shot per accepted word.

Ports:
sys_clk  in  1  system clock (one clock domain)
sys_rst_n  in  1  asynchronous active-low reset
din  in  DATA_W  word to send
din_valid  in  1  din is valid; must hold until accepted
din_ready  out  1  block can accept din this cycle
out_en  in  1  1: 595 outputs enabled once a word has been latched
ds  out  1  serial data to first 595
shcp  out  1  shift clock, rising edge shifts
stcp  out  1  storage clock, rising edge latches
oe  out  1  active-low output enable to 595s
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of each latch

Behaviour:
- Reset applies immediately (async) and sets every register to these values:
  - outputs: ds=0, shcp=0, stcp=0, oe=1, busy=0, done=0, din_ready=0 while asserted;
  - internal state: shadow word=0, first-latch flag=0, FSM=IDLE.
  - Reset mid-frame aborts the frame with no stcp pulse.
- All outputs are registered except din_ready, which is combinational: 1 exactly when FSM==IDLE and out of reset.
- FSM states:
  - IDLE -> SHIFT on din_valid&din_ready: din is captured into the shadow word.
  - IDLE -> SHIFT also when AUTO_REFRESH=1, din_valid=0 and first-latch flag=1: the shadow word is re-sent, and each auto-refresh IDLE lasts exactly 1 cycle.
  - SHIFT -> LATCH after bit DATA_W-1 completes.
  - LATCH -> IDLE after CLK_DIV cycles.
- Timing: let T0 be the first cycle after the accepting/starting edge.
  - Bit k (k=0..DATA_W-1) occupies cycles T0+k*CLK_DIV .. T0+(k+1)*CLK_DIV-1.
  - Within that window ds holds bit k for all cycles.
  - shcp=0 for the first CLK_DIV/2 cycles of the window and 1 for the last CLK_DIV/2, so ds is stable >= CLK_DIV/2 cycles around each shcp rise.
  - Bit k is shadow[k] if MSB_FIRST=0, else shadow[DATA_W-1-k].
- LATCH window: cycles T0+DATA_W*CLK_DIV .. +CLK_DIV-1.
  - shcp=0 throughout.
  - ds holds the last bit.
  - stcp=1 for the first CLK_DIV/2 cycles, then 0.
  - done=1 on the last LATCH cycle only; the first-latch flag is set on that same cycle.
- busy=1 exactly in SHIFT and LATCH, i.e. DATA_W*CLK_DIV+CLK_DIV cycles per frame.
- stcp is 0 and shcp is 0 whenever FSM is IDLE.
- oe=1 until the first-latch flag is set; afterwards oe = ~out_en, registered (1-cycle latency). Garbage never reaches the LEDs after reset.
- din_valid while busy: ignored; din changes mid-frame do not affect the frame (the shadow word is used).
- din_valid arriving in the same cycle done=1: not accepted until the following IDLE cycle. That IDLE cycle accepts it with priority over auto-refresh.
- Counter widths: phase counter $clog2(CLK_DIV); bit counter $clog2(DATA_W+1). The bit counter wraps to 0 on leaving LATCH and never exceeds DATA_W-1.
- DATA_W=1 is legal: one shift window, then LATCH.

Decomposition:
- Package hc595_pkg:
  - FSM state encoding (IDLE, SHIFT, LATCH) as localparams/enum;
  - helper function for bit-counter width.
- Sub-module hc595_bit_timer:
  - CLK_DIV phase counter with run/clear inputs;
  - outputs phase_first, phase_half and phase_last strobes, used by the parent for shcp/stcp levels and bit-counter advance.
- The FSM, shadow word, bit select and oe logic stay in hc_595-style parent hc595_chain_ctrl.

Test Plan:
1. Defaults, reset released, din=14'h2A5C with valid for 1 cycle -> accepted on first IDLE edge.
   - busy high 60 cycles; 14 shcp rises spaced 4 cycles apart.
   - ds sequence equals din[0..13] sampled at each shcp rise.
   - One stcp pulse 2 cycles wide after the 14th rise; done pulses once.
2. MSB_FIRST=1, DATA_W=16, CLK_DIV=2, din=16'h8001 -> bits sampled at shcp rises are 1,0x14,1; busy length 34 cycles.
3. AUTO_REFRESH=1, single word 14'h0F0F, then no valid -> identical frames repeat every 61 cycles (60 busy + 1 IDLE).
   - New din 14'h3FFF asserted mid-frame is held by the source and sent in the very next frame; din_ready is 0 throughout busy.
4. oe blanking: out_en=1 from reset -> oe stays 1 until done of the first frame, then 0 one cycle later.
   - Toggling out_en to 0 -> oe=1 next cycle.
5. Reset asserted at bit 7 of a frame -> same cycle ds=shcp=stcp=0, oe=1, busy=0.
   - After release with AUTO_REFRESH=1 and no valid: no frame starts (first-latch flag cleared).
6. AUTO_REFRESH=0, din_valid held continuously with values 1,2,3 -> three back-to-back frames each separated by exactly 1 IDLE cycle.
   - Then idle forever once valid drops; done pulses exactly 3 times.
